mem_controller: RTL and testbench

MEM_CONTROLLER -- requirements
Module: mem_controller

---
 rtl/mem_ctrl_pkg.sv | 15 +
 rtl/mem_controller.sv | 92 +++++++++
 tb/tb_mem_controller.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared defaults and FSM state encoding for the burst memory controller.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned LEN_W_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RTAIL = 2'd3
  } state_t;

endpackage

// File: rtl/mem_controller.sv
// Burst memory controller: accepts one client burst at a time and sequences
// word writes or pipelined reads against a registered-address RAM.
module mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic              mem_clk,
  input  logic              mem_rst,
  input  logic              cl_req,
  input  logic              cl_we,
  input  logic [ADDR_W-1:0] cl_addr,
  input  logic [LEN_W-1:0]  cl_len,
  input  logic [DATA_W-1:0] cl_wdata,
  output logic              cl_ack,
  output logic              cl_wready,
  output logic [DATA_W-1:0] cl_rdata,
  output logic              cl_rvalid,
  output logic              cl_busy,
  output logic [ADDR_W-1:0] mc_address_mem,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] beat_cnt;
  logic             rd_pend;

  always_comb begin
    state_nxt   = state;
    cl_wready   = 1'b0;
    cl_busy     = 1'b1;
    mem_data_in = '0;
    unique case (state)
      ST_IDLE: begin
        cl_busy = 1'b0;
        if (cl_req) state_nxt = cl_we ? ST_WRITE : ST_READ;
      end
      ST_WRITE: begin
        cl_wready   = 1'b1;
        mem_data_in = cl_wdata;
        if (beat_cnt == '0) state_nxt = ST_IDLE;
      end
      ST_READ: begin
        if (beat_cnt == '0) state_nxt = ST_RTAIL;
      end
      ST_RTAIL: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) begin
      state          <= ST_IDLE;
      beat_cnt       <= '0;
      mc_address_mem <= '0;
      mem_we         <= 1'b0;
      cl_ack         <= 1'b0;
      rd_pend        <= 1'b0;
      cl_rvalid      <= 1'b0;
      cl_rdata       <= '0;
    end else begin
      state   <= state_nxt;
      mem_we  <= (state_nxt == ST_WRITE);
      cl_ack  <= (state == ST_IDLE) && cl_req;
      // rd_pend marks an address the RAM samples on this edge; its data is
      // captured one edge later, giving the two-edge read latency.
      rd_pend   <= (state == ST_READ);
      cl_rvalid <= rd_pend;
      if (rd_pend) cl_rdata <= mem_data_out;
      case (state)
        ST_IDLE: begin
          if (cl_req) begin
            mc_address_mem <= cl_addr;
            beat_cnt       <= cl_len;
          end
        end
        ST_WRITE, ST_READ: begin
          mc_address_mem <= mc_address_mem + ADDR_W'(1);
          beat_cnt       <= beat_cnt - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_controller.sv
// Self-checking bench for mem_controller with a registered-address RAM beside it
// and a word-level shadow memory as the reference.
module tb_mem_controller;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;
  localparam int DEPTH  = 64;

  logic              mem_clk = 1'b0;
  logic              mem_rst = 1'b0;
  logic              cl_req = 1'b0;
  logic              cl_we = 1'b0;
  logic [ADDR_W-1:0] cl_addr = '0;
  logic [LEN_W-1:0]  cl_len = '0;
  logic [DATA_W-1:0] cl_wdata = '0;
  logic              cl_ack;
  logic              cl_wready;
  logic [DATA_W-1:0] cl_rdata;
  logic              cl_rvalid;
  logic              cl_busy;
  logic [ADDR_W-1:0] mc_address_mem;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_we;
  logic [DATA_W-1:0] mem_data_out;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] ref_mem   [DEPTH];
  bit                ref_known [DEPTH];

  mem_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .mem_clk        (mem_clk),
    .mem_rst        (mem_rst),
    .cl_req         (cl_req),
    .cl_we          (cl_we),
    .cl_addr        (cl_addr),
    .cl_len         (cl_len),
    .cl_wdata       (cl_wdata),
    .cl_ack         (cl_ack),
    .cl_wready      (cl_wready),
    .cl_rdata       (cl_rdata),
    .cl_rvalid      (cl_rvalid),
    .cl_busy        (cl_busy),
    .mc_address_mem (mc_address_mem),
    .mem_data_in    (mem_data_in),
    .mem_we         (mem_we),
    .mem_data_out   (mem_data_out)
  );

  always #5 mem_clk = ~mem_clk;

  // RAM: registered address, read data one cycle after the address is presented.
  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] ram_q;
  always @(posedge mem_clk) begin
    if (mem_we) ram[mc_address_mem] <= mem_data_in;
    ram_q <= ram[mc_address_mem];
  end
  assign mem_data_out = ram_q;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, observed no end, expected summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " mem_we"},    64'(mem_we),         64'(0));
    chk({tag, " wready"},    64'(cl_wready),      64'(0));
    chk({tag, " ack"},       64'(cl_ack),         64'(0));
    chk({tag, " rvalid"},    64'(cl_rvalid),      64'(0));
    chk({tag, " busy"},      64'(cl_busy),        64'(0));
    chk({tag, " rdata"},     64'(cl_rdata),       64'(0));
    chk({tag, " addr"},      64'(mc_address_mem), 64'(0));
    chk({tag, " data_in"},   64'(mem_data_in),    64'(0));
  endtask

  // Issues one burst starting in the current cycle and checks every cycle of it.
  // Returns in the first cycle a new request would be accepted; abort_k >= 0
  // asserts mem_rst in that cycle of the burst and returns with reset released.
  task automatic run_burst(input bit we, input int addr, input int len, input bit hold,
                           input int abort_k, input bit seq, input logic [DATA_W-1:0] base);
    logic [DATA_W-1:0] wd [16];
    int a;
    for (int i = 0; i < 16; i++) wd[i] = seq ? base + DATA_W'(i) : DATA_W'($urandom);
    cl_req   = 1'b1;
    cl_we    = we;
    cl_addr  = ADDR_W'(addr);
    cl_len   = LEN_W'(len);
    cl_wdata = wd[0];
    @(posedge mem_clk); #1;
    if (!hold) cl_req = 1'b0;
    if (we) begin
      for (int k = 0; k <= len + 1; k++) begin
        a = (addr + k) % DEPTH;
        if (k == abort_k) begin
          mem_rst = 1'b1;
          cl_req  = 1'b0;
          ref_known[a] = 1'b0;
          #1;
          chk_reset_outputs("wr_abort");
          #1 mem_rst = 1'b0;
          return;
        end
        if (k <= len) cl_wdata = wd[k];
        #1;
        chk("wr ack",    64'(cl_ack),    64'(k == 0));
        chk("wr busy",   64'(cl_busy),   64'(k <= len));
        chk("wr wready", 64'(cl_wready), 64'(k <= len));
        chk("wr mem_we", 64'(mem_we),    64'(k <= len));
        chk("wr rvalid", 64'(cl_rvalid), 64'(0));
        if (k <= len) begin
          chk("wr addr",    64'(mc_address_mem), 64'(a));
          chk("wr data_in", 64'(mem_data_in),    64'(wd[k]));
          @(posedge mem_clk); #1;
          ref_mem[a]   = wd[k];
          ref_known[a] = 1'b1;
        end else begin
          chk("wr idle data_in", 64'(mem_data_in), 64'(0));
        end
      end
    end else begin
      for (int k = 0; k <= len + 2; k++) begin
        if (k == abort_k) begin
          mem_rst = 1'b1;
          cl_req  = 1'b0;
          #1;
          chk_reset_outputs("rd_abort");
          #1 mem_rst = 1'b0;
          return;
        end
        #1;
        chk("rd ack",     64'(cl_ack),      64'(k == 0));
        chk("rd busy",    64'(cl_busy),     64'(k <= len + 1));
        chk("rd rvalid",  64'(cl_rvalid),   64'(k >= 2));
        chk("rd wready",  64'(cl_wready),   64'(0));
        chk("rd mem_we",  64'(mem_we),      64'(0));
        chk("rd data_in", 64'(mem_data_in), 64'(0));
        if (k <= len) chk("rd addr", 64'(mc_address_mem), 64'((addr + k) % DEPTH));
        if (k >= 2) begin
          a = (addr + k - 2) % DEPTH;
          if (ref_known[a]) chk("rd rdata", 64'(cl_rdata), 64'(ref_mem[a]));
        end
        if (k < len + 2) begin
          @(posedge mem_clk); #1;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;
    #2 mem_rst = 1'b1;
    #1;
    chk_reset_outputs("reset_async");
    @(posedge mem_clk); #1;
    chk_reset_outputs("reset_held");
    mem_rst = 1'b0;

    // Fill the whole RAM; the first request goes in right after reset release.
    for (int i = 0; i < 4; i++) run_burst(1'b1, i * 16, 15, 1'b0, -1, 1'b0, '0);

    // Single write/read of a known word.
    run_burst(1'b1, 5, 0, 1'b0, -1, 1'b1, 32'hDEADBEEF);
    run_burst(1'b0, 5, 0, 1'b0, -1, 1'b0, '0);
    chk("deadbeef model", 64'(ref_mem[5]), 64'(32'hDEADBEEF));

    // Wrapping burst across the top of the address space.
    run_burst(1'b1, 60, 7, 1'b0, -1, 1'b1, 32'h100);
    run_burst(1'b0, 60, 7, 1'b0, -1, 1'b0, '0);
    chk("wrap ram[63]", 64'(ram[63]), 64'(32'h103));
    chk("wrap ram[0]",  64'(ram[0]),  64'(32'h104));

    // Request held high through a 16-beat read: second ack only after busy falls.
    run_burst(1'b0, 20, 15, 1'b1, -1, 1'b0, '0);
    run_burst(1'b0, 20, 15, 1'b0, -1, 1'b0, '0);

    // Back-to-back read then write with no idle gap.
    run_burst(1'b0, 8, 3, 1'b0, -1, 1'b0, '0);
    run_burst(1'b1, 40, 2, 1'b0, -1, 1'b0, '0);

    // Reset in the third beat of a 16-beat write, then read the region back.
    run_burst(1'b1, 0, 15, 1'b0, 2, 1'b0, '0);
    run_burst(1'b0, 0, 15, 1'b0, -1, 1'b0, '0);

    // Reset mid-read: no read data may appear afterwards.
    run_burst(1'b0, 10, 7, 1'b0, 3, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      @(posedge mem_clk); #1;
      chk("post_abort rvalid", 64'(cl_rvalid), 64'(0));
      chk("post_abort busy",   64'(cl_busy),   64'(0));
    end

    // Random bursts against the shadow memory.
    for (int i = 0; i < 24; i++)
      run_burst(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                int'($urandom_range(0, 15)), 1'b0, -1, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
